// File: rtl/mq_mul_seq.sv
// Radix-4 Booth multiply step sequencer: walks the MQ low bit pair for N steps,
// steering the AD operation and the AR/MQ load/shift strobes, then pulses done.
module mq_mul_seq (
    input  logic       clk,
    input  logic       resetN,
    input  logic       start,
    input  logic [5:0] steps,
    input  logic       abort,
    input  logic [1:0] mqLow,      // [1] = MQ[34], [0] = MQ[35] (LSB)
    output logic       busy,
    output logic       done,
    output logic [2:0] adOp,
    output logic       arLoad,
    output logic       mqShift,
    output logic [5:0] stepsLeft
);

    localparam logic [2:0] OP_PASS  = 3'b000;
    localparam logic [2:0] OP_ADD1  = 3'b001;
    localparam logic [2:0] OP_ADD2  = 3'b010;
    localparam logic [2:0] OP_SUB1  = 3'b011;
    localparam logic [2:0] OP_SUB2  = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        STEP = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t     state, state_nxt;
    logic [5:0] cnt, cnt_nxt;
    logic       prev_bit, prev_bit_nxt;
    logic [2:0] booth_op;

    // Triplet is {MQ[34], MQ[35], bit shifted out on the previous step}.
    always_comb begin
        booth_op = OP_PASS;
        case ({mqLow[1], mqLow[0], prev_bit})
            3'b000, 3'b111: booth_op = OP_PASS;
            3'b001, 3'b010: booth_op = OP_ADD1;
            3'b011:         booth_op = OP_ADD2;
            3'b100:         booth_op = OP_SUB2;
            3'b101, 3'b110: booth_op = OP_SUB1;
            default:        booth_op = OP_PASS;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state    <= IDLE;
            cnt      <= '0;
            prev_bit <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            prev_bit <= prev_bit_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        prev_bit_nxt = prev_bit;
        busy         = 1'b0;
        done         = 1'b0;
        adOp         = OP_PASS;
        arLoad       = 1'b0;
        mqShift      = 1'b0;

        case (state)
            IDLE: begin
                if (start && !abort) begin
                    cnt_nxt      = steps;
                    prev_bit_nxt = 1'b0;
                    state_nxt    = (steps == 6'd0) ? DONE : STEP;
                end
            end
            STEP: begin
                busy         = 1'b1;
                adOp         = booth_op;
                arLoad       = 1'b1;
                mqShift      = 1'b1;
                prev_bit_nxt = mqLow[1];
                // Saturating count: a zero here can only mean the last step.
                if (cnt <= 6'd1) begin
                    cnt_nxt   = 6'd0;
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt - 6'd1;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        // Abort overrides everything, including same-cycle strobes.
        if (abort) begin
            state_nxt = IDLE;
            cnt_nxt   = 6'd0;
            done      = 1'b0;
            adOp      = OP_PASS;
            arLoad    = 1'b0;
            mqShift   = 1'b0;
        end
    end

    assign stepsLeft = cnt;

endmodule

// File: tb/tb_mq_mul_seq.sv
// Directed bench for mq_mul_seq: Booth decode table plus multi-cycle sequences
// (basic run, zero steps, abort, ignored start, async reset, full 18-step run).
module tb_mq_mul_seq;

    logic       clk = 1'b0;
    logic       resetN;
    logic       start;
    logic [5:0] steps;
    logic       abort;
    logic [1:0] mqLow;
    logic       busy, done, arLoad, mqShift;
    logic [2:0] adOp;
    logic [5:0] stepsLeft;

    int checks = 0;
    int errors = 0;

    localparam logic [2:0] PASS_OP = 3'b000;
    localparam logic [2:0] ADD1    = 3'b001;
    localparam logic [2:0] ADD2    = 3'b010;
    localparam logic [2:0] SUB1    = 3'b011;
    localparam logic [2:0] SUB2    = 3'b100;

    mq_mul_seq dut (
        .clk(clk), .resetN(resetN), .start(start), .steps(steps), .abort(abort),
        .mqLow(mqLow), .busy(busy), .done(done), .adOp(adOp), .arLoad(arLoad),
        .mqShift(mqShift), .stepsLeft(stepsLeft)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference Booth recoding, written from the operation table.
    function automatic logic [2:0] booth_ref(input logic [1:0] mq, input logic pb);
        logic signed [3:0] w;
        w = -2 * $signed({3'b000, mq[1]}) + $signed({3'b000, mq[0]}) + $signed({3'b000, pb});
        case (w)
            4'sd1:   return ADD1;
            4'sd2:   return ADD2;
            -4'sd1:  return SUB1;
            -4'sd2:  return SUB2;
            default: return PASS_OP;
        endcase
    endfunction

    // Present start for one edge; returns at the negedge of the first STEP cycle.
    task automatic go(input logic [5:0] n, input logic [1:0] mq);
        @(negedge clk);
        start = 1'b1;
        steps = n;
        mqLow = mq;
        @(negedge clk);
        start = 1'b0;
    endtask

    typedef struct {
        logic [1:0] mq_prev;
        logic [1:0] mq_cur;
        logic [2:0] exp_op;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int cnt;
        int seen;
        logic pb;

        tbl[0] = '{2'b00, 2'b00, PASS_OP};  // 000
        tbl[1] = '{2'b10, 2'b00, ADD1};     // 001
        tbl[2] = '{2'b00, 2'b01, ADD1};     // 010
        tbl[3] = '{2'b10, 2'b01, ADD2};     // 011
        tbl[4] = '{2'b00, 2'b10, SUB2};     // 100
        tbl[5] = '{2'b10, 2'b10, SUB1};     // 101
        tbl[6] = '{2'b00, 2'b11, SUB1};     // 110
        tbl[7] = '{2'b10, 2'b11, PASS_OP};  // 111

        resetN = 1'b0; start = 1'b0; steps = '0; abort = 1'b0; mqLow = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_adop", adOp, 0);
        chk("rst_arload", arLoad, 0);
        chk("rst_mqshift", mqShift, 0);
        chk("rst_steps", stepsLeft, 0);
        resetN = 1'b1;

        // Basic three-step run, mqLow=01 throughout
        go(6'd3, 2'b01);
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            chk("basic_busy", busy, 1);
            chk("basic_adop", adOp, ADD1);
            chk("basic_arload", arLoad, 1);
            chk("basic_mqshift", mqShift, 1);
            chk("basic_left", stepsLeft, 3 - k);
            chk("basic_nodone", done, 0);
        end
        @(negedge clk); #1;
        chk("basic_done", done, 1);
        chk("basic_done_busy", busy, 0);
        chk("basic_done_arload", arLoad, 0);
        chk("basic_done_left", stepsLeft, 0);
        @(negedge clk); #1;
        chk("basic_idle_done", done, 0);
        chk("basic_idle_busy", busy, 0);

        // Booth sequence 11,10,00: prevBit follows MQ[34] of the prior step
        go(6'd3, 2'b11);
        #1 chk("seq_op1", adOp, SUB1);      // 110
        @(negedge clk); mqLow = 2'b10;
        #1 chk("seq_op2", adOp, SUB1);      // 101
        @(negedge clk); mqLow = 2'b00;
        #1 chk("seq_op3", adOp, ADD1);      // 001
        @(negedge clk); #1 chk("seq_done", done, 1);
        @(negedge clk);

        // Full decode table via two-step runs
        for (int i = 0; i < 8; i++) begin
            go(6'd2, tbl[i].mq_prev);
            @(negedge clk); mqLow = tbl[i].mq_cur;
            #1 chk($sformatf("tbl%0d_op", i), adOp, tbl[i].exp_op);
            @(negedge clk); #1 chk($sformatf("tbl%0d_done", i), done, 1);
            @(negedge clk);
        end

        // Zero-step request
        go(6'd0, 2'b01);
        #1;
        chk("zero_done", done, 1);
        chk("zero_busy", busy, 0);
        chk("zero_arload", arLoad, 0);
        @(negedge clk); #1;
        chk("zero_after", done, 0);
        chk("zero_after_busy", busy, 0);

        // Abort at step 5 of 18
        go(6'd18, 2'b01);
        repeat (4) @(negedge clk);
        abort = 1'b1;
        #1;
        chk("abort_left_before", stepsLeft, 14);
        chk("abort_arload", arLoad, 0);
        chk("abort_mqshift", mqShift, 0);
        chk("abort_adop", adOp, 0);
        @(negedge clk); abort = 1'b0;
        #1;
        chk("abort_idle", busy, 0);
        chk("abort_left", stepsLeft, 0);
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            if (done) seen++;
        end
        chk("abort_nodone", seen, 0);

        // Abort during DONE masks the pulse
        go(6'd1, 2'b00);
        @(negedge clk); abort = 1'b1;
        #1 chk("abort_done_mask", done, 0);
        @(negedge clk); abort = 1'b0;

        // start with abort in IDLE stays idle
        @(negedge clk); start = 1'b1; abort = 1'b1; steps = 6'd4;
        @(negedge clk); start = 1'b0; abort = 1'b0;
        #1;
        chk("startabort_busy", busy, 0);
        chk("startabort_left", stepsLeft, 0);

        // Start ignored in STEP, then async reset between edges
        go(6'd5, 2'b00);
        #1 chk("ign_left0", stepsLeft, 5);
        @(negedge clk); start = 1'b1; steps = 6'd40;
        #1 chk("ign_left1", stepsLeft, 4);
        @(negedge clk); start = 1'b0; mqLow = 2'b01;
        #1 chk("ign_left2", stepsLeft, 3);
        #1 resetN = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_arload", arLoad, 0);
        chk("arst_mqshift", mqShift, 0);
        chk("arst_adop", adOp, 0);
        chk("arst_left", stepsLeft, 0);
        #1 resetN = 1'b1;
        seen = 0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            if (done) seen++;
            if (busy) cnt++;
        end
        chk("arst_nodone", seen, 0);
        chk("arst_nobusy", cnt, 0);

        // Full 18-step run with random mqLow against the reference model
        go(6'd18, 2'($urandom_range(0, 3)));
        pb = 1'b0;
        cnt = 0;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            #1;
            if (arLoad) begin
                cnt++;
                chk($sformatf("full_op%0d", cnt), adOp, booth_ref(mqLow, pb));
                pb = mqLow[1];
            end
            if (done) seen++;
            @(negedge clk);
            mqLow = 2'($urandom_range(0, 3));
        end
        chk("full_steps", cnt, 18);
        chk("full_done", seen, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
